// File: rtl/cv32e40p_reconfig_controller_if.sv
// Breakage-monitor / core-halt interface of the TMR reconfiguration controller.
// master = controller side, slave = monitors, core and voter side.
interface cv32e40p_reconfig_controller_if #(
  parameter int CNT_BIT = 8
);
  logic [2:0]         is_broken_i;
  logic               halt_ack_i;
  logic               halt_req_o;
  logic [2:0]         set_broken_o;
  logic [2:0]         replica_en_o;
  logic [1:0]         voter_mode_o;
  logic               fatal_o;
  logic               timeout_o;
  logic [CNT_BIT-1:0] reconfig_count_o;

  modport master (
    input  is_broken_i, halt_ack_i,
    output halt_req_o, set_broken_o, replica_en_o, voter_mode_o,
           fatal_o, timeout_o, reconfig_count_o
  );

  modport slave (
    output is_broken_i, halt_ack_i,
    input  halt_req_o, set_broken_o, replica_en_o, voter_mode_o,
           fatal_o, timeout_o, reconfig_count_o
  );
endinterface

// File: rtl/cv32e40p_reconfig_controller.sv
// TMR reconfiguration controller: sticky broken mask, halt handshake, TMR->DMR->SIMPLEX->FAIL.
// Optional reconfiguration event counter built when RECONFIG_EVENT_COUNTER_EN is defined.
module cv32e40p_reconfig_controller #(
  parameter int ACK_TIMEOUT   = 16,
  parameter int TIMEOUT_BIT   = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int SETTLE_BIT    = 3,
  parameter int CNT_BIT       = 8
) (
  input  logic                                clk_gated,
  input  logic                                rst_n,
  cv32e40p_reconfig_controller_if.master      rc
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HALT_REQ = 3'd1;
  localparam logic [2:0] RECONFIG = 3'd2;
  localparam logic [2:0] SETTLE   = 3'd3;
  localparam logic [2:0] RESUME   = 3'd4;
  localparam logic [2:0] FATAL    = 3'd5;

  logic [2:0]             state_q;
  logic [2:0]             broken_mask_q;
  logic [2:0]             pending_q;
  logic [2:0]             set_broken_q;
  logic [2:0]             replica_en_q;
  logic [1:0]             voter_mode_q;
  logic                   halt_req_q;
  logic                   fatal_q;
  logic                   timeout_q;
  logic [TIMEOUT_BIT-1:0] tcnt_q;
  logic [SETTLE_BIT-1:0]  scnt_q;

  logic [2:0] new_break;
  logic [2:0] pending_all;
  logic [2:0] mask_next;

  // Once fatal, the inputs are no longer observed at all.
  assign new_break   = (state_q == FATAL) ? 3'b000
                                          : (rc.is_broken_i & ~broken_mask_q & ~pending_q);
  assign pending_all = pending_q | new_break;
  assign mask_next   = broken_mask_q | pending_q;

  function automatic logic [1:0] mode_of(input logic [2:0] en);
    logic [1:0] m;
    case (en)
      3'b111:                 m = 2'b00;
      3'b110, 3'b101, 3'b011: m = 2'b01;
      3'b100, 3'b010, 3'b001: m = 2'b10;
      default:                m = 2'b11;
    endcase
    return m;
  endfunction

  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      broken_mask_q <= 3'b000;
      pending_q     <= 3'b000;
      set_broken_q  <= 3'b000;
      replica_en_q  <= 3'b111;
      voter_mode_q  <= 2'b00;
      halt_req_q    <= 1'b0;
      fatal_q       <= 1'b0;
      timeout_q     <= 1'b0;
      tcnt_q        <= '0;
      scnt_q        <= '0;
    end else begin
      set_broken_q <= 3'b000;
      pending_q    <= pending_all;
      case (state_q)
        IDLE: begin
          if (pending_all != 3'b000) begin
            state_q    <= HALT_REQ;
            halt_req_q <= 1'b1;
          end
        end
        HALT_REQ: begin
          if (rc.halt_ack_i) begin
            state_q <= RECONFIG;
            tcnt_q  <= '0;
          end else if (tcnt_q == TIMEOUT_BIT'(ACK_TIMEOUT - 1)) begin
            state_q   <= RECONFIG;
            timeout_q <= 1'b1;
            tcnt_q    <= '0;
          end else begin
            tcnt_q <= tcnt_q + TIMEOUT_BIT'(1);
          end
        end
        // Retire everything pending in one step; breaks seen this cycle wait for the next round.
        RECONFIG: begin
          broken_mask_q <= mask_next;
          set_broken_q  <= pending_q;
          pending_q     <= new_break;
          replica_en_q  <= ~mask_next;
          voter_mode_q  <= mode_of(~mask_next);
          scnt_q        <= '0;
          if (mask_next == 3'b111) begin
            state_q <= FATAL;
            fatal_q <= 1'b1;
          end else begin
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (scnt_q == SETTLE_BIT'(SETTLE_CYCLES - 1)) begin
            scnt_q <= '0;
            if (pending_q != 3'b000) begin
              state_q <= RECONFIG;
            end else begin
              state_q    <= RESUME;
              halt_req_q <= 1'b0;
            end
          end else begin
            scnt_q <= scnt_q + SETTLE_BIT'(1);
          end
        end
        RESUME: state_q <= IDLE;
        FATAL:  state_q <= FATAL;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rc.halt_req_o   = halt_req_q;
  assign rc.set_broken_o = set_broken_q;
  assign rc.replica_en_o = replica_en_q;
  assign rc.voter_mode_o = voter_mode_q;
  assign rc.fatal_o      = fatal_q;
  assign rc.timeout_o    = timeout_q;

`ifdef RECONFIG_EVENT_COUNTER_EN
  logic [CNT_BIT-1:0] count_q;

  // Saturating count of RECONFIG cycles.
  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if ((state_q == RECONFIG) && (count_q != {CNT_BIT{1'b1}})) begin
      count_q <= count_q + CNT_BIT'(1);
    end
  end

  assign rc.reconfig_count_o = count_q;
`else
  assign rc.reconfig_count_o = {CNT_BIT{1'b0}};
`endif

endmodule

// File: tb/tb_cv32e40p_reconfig_controller.sv
// Scoreboard bench for cv32e40p_reconfig_controller; expected pulses are queued at stimulus time.
// Honours RECONFIG_EVENT_COUNTER_EN for the expected event count.
module tb_cv32e40p_reconfig_controller;

  logic clk_gated;
  logic rst_n;
  int   tests;
  int   fails;

  cv32e40p_reconfig_controller_if #(.CNT_BIT(8)) bus ();

  cv32e40p_reconfig_controller dut (
    .clk_gated (clk_gated),
    .rst_n     (rst_n),
    .rc        (bus)
  );

  initial clk_gated = 1'b0;
  always #5 clk_gated = ~clk_gated;

  typedef struct packed {
    logic [2:0] sb;
    logic [2:0] en;
    logic [1:0] vm;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sbq[$];
  logic [2:0] model_mask;
  logic [7:0] model_cnt;

  // Reference model: one queued entry per expected set_broken_o pulse.
  function automatic void push_expect(input logic [2:0] bits);
    exp_t e;
    int   live;
    model_mask = model_mask | bits;
    live       = $countones(~model_mask);
    if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
    e.sb = bits;
    e.en = ~model_mask;
    e.vm = (live == 3) ? 2'b00 : (live == 2) ? 2'b01 : (live == 1) ? 2'b10 : 2'b11;
`ifdef RECONFIG_EVENT_COUNTER_EN
    e.cnt = model_cnt;
`else
    e.cnt = 8'd0;
`endif
    sbq.push_back(e);
  endfunction

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.is_broken_i = 3'b000;
    bus.halt_ack_i  = 1'b0;
    model_mask      = 3'b000;
    model_cnt       = 8'd0;
    sbq.delete();
    repeat (2) @(posedge clk_gated);
    @(negedge clk_gated);
    rst_n = 1'b1;
    @(posedge clk_gated);
    #1;
  endtask

  task automatic drive_break(input logic [2:0] val);
    @(posedge clk_gated);
    #1;
    bus.is_broken_i = val;
  endtask

  task automatic wait_pulse(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_gated);
      if (bus.set_broken_o != 3'b000) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_halt_low(input int budget, output int n);
    n = budget;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk_gated);
      if (!bus.halt_req_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_gated);
    tests++; if (bus.halt_req_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_halt: got %b expected 0", bus.halt_req_o); end
    tests++; if (bus.set_broken_o !== 3'b000) begin fails++; $display("[TB] FAIL reset_set_broken: got %b expected 000", bus.set_broken_o); end
    tests++; if (bus.replica_en_o !== 3'b111) begin fails++; $display("[TB] FAIL reset_en: got %b expected 111", bus.replica_en_o); end
    tests++; if (bus.voter_mode_o !== 2'b00) begin fails++; $display("[TB] FAIL reset_mode: got %b expected 00", bus.voter_mode_o); end
    tests++; if (bus.fatal_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_fatal: got %b expected 0", bus.fatal_o); end
    tests++; if (bus.timeout_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout: got %b expected 0", bus.timeout_o); end
    tests++; if (bus.reconfig_count_o !== 8'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.reconfig_count_o); end
  endtask

  task automatic test_single_break();
    bit   seen;
    int   lat;
    int   n;
    bit   extra;
    exp_t e;
    exp_t o;
    do_reset();
    bus.is_broken_i = 3'b010;
    push_expect(3'b010);
    lat = 99;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_gated);
      if (bus.halt_req_o) begin lat = i; break; end
    end
    tests++; if (lat != 1) begin fails++; $display("[TB] FAIL single_halt_latency: got %0d expected 1", lat); end
    repeat (3) @(posedge clk_gated);
    #1;
    bus.halt_ack_i = 1'b1;
    wait_pulse(10, seen);
    tests++;
    if (!seen || sbq.size() == 0) begin
      fails++; $display("[TB] FAIL single_pulse: got no pulse or no queued entry (seen=%0b)", seen);
    end else begin
      e = sbq.pop_front();
      o = {bus.set_broken_o, bus.replica_en_o, bus.voter_mode_o, bus.reconfig_count_o};
      if (o !== e) begin fails++; $display("[TB] FAIL single_pulse: got %b expected %b", o, e); end
    end
    extra = 1'b0;
    n = 99;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_gated);
      if (bus.set_broken_o != 3'b000) extra = 1'b1;
      if (!bus.halt_req_o) begin n = k; break; end
    end
    tests++; if (extra !== 1'b0) begin fails++; $display("[TB] FAIL single_pulse_width: got extra pulse %b expected 0", extra); end
    tests++; if (n != 4) begin fails++; $display("[TB] FAIL single_settle_len: got %0d expected 4", n); end
    bus.halt_ack_i = 1'b0;
    extra = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_gated);
      if (bus.set_broken_o != 3'b000 || bus.halt_req_o) extra = 1'b1;
    end
    tests++; if (extra !== 1'b0) begin fails++; $display("[TB] FAIL single_masked_quiet: got activity %b expected 0", extra); end
    bus.is_broken_i = 3'b000;
    repeat (3) @(negedge clk_gated);
    tests++; if (bus.replica_en_o !== 3'b101) begin fails++; $display("[TB] FAIL single_sticky: got %b expected 101", bus.replica_en_o); end
  endtask

  task automatic test_simultaneous();
    bit   seen;
    int   n;
    exp_t e;
    exp_t o;
    do_reset();
    bus.halt_ack_i  = 1'b1;
    bus.is_broken_i = 3'b101;
    push_expect(3'b101);
    wait_pulse(10, seen);
    tests++;
    if (!seen || sbq.size() == 0) begin
      fails++; $display("[TB] FAIL simul_pulse: got no pulse or no queued entry (seen=%0b)", seen);
    end else begin
      e = sbq.pop_front();
      o = {bus.set_broken_o, bus.replica_en_o, bus.voter_mode_o, bus.reconfig_count_o};
      if (o !== e) begin fails++; $display("[TB] FAIL simul_pulse: got %b expected %b", o, e); end
    end
    wait_halt_low(12, n);
    bus.halt_ack_i = 1'b0;
  endtask

  task automatic test_timeout();
    bit   seen;
    int   hold;
    exp_t e;
    exp_t o;
    do_reset();
    bus.is_broken_i = 3'b001;
    push_expect(3'b001);
    hold = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_gated);
      if (bus.timeout_o) begin seen = 1'b1; break; end
      if (bus.halt_req_o) hold++;
    end
    tests++; if (!seen || hold != 16) begin fails++; $display("[TB] FAIL timeout_cycles: got seen=%0b hold=%0d expected seen=1 hold=16", seen, hold); end
    wait_pulse(10, seen);
    tests++;
    if (!seen || sbq.size() == 0) begin
      fails++; $display("[TB] FAIL timeout_pulse: got no pulse or no queued entry (seen=%0b)", seen);
    end else begin
      e = sbq.pop_front();
      o = {bus.set_broken_o, bus.replica_en_o, bus.voter_mode_o, bus.reconfig_count_o};
      if (o !== e) begin fails++; $display("[TB] FAIL timeout_pulse: got %b expected %b", o, e); end
    end
    repeat (8) @(negedge clk_gated);
    tests++; if (bus.timeout_o !== 1'b1) begin fails++; $display("[TB] FAIL timeout_sticky: got %b expected 1", bus.timeout_o); end
  endtask

  task automatic test_settle_second_break();
    bit   seen;
    bit   dropped;
    int   n;
    exp_t e;
    exp_t o;
    do_reset();
    bus.halt_ack_i  = 1'b1;
    bus.is_broken_i = 3'b001;
    push_expect(3'b001);
    wait_pulse(10, seen);
    tests++;
    if (!seen || sbq.size() == 0) begin
      fails++; $display("[TB] FAIL settle_first_pulse: got no pulse or no queued entry (seen=%0b)", seen);
    end else begin
      e = sbq.pop_front();
      o = {bus.set_broken_o, bus.replica_en_o, bus.voter_mode_o, bus.reconfig_count_o};
      if (o !== e) begin fails++; $display("[TB] FAIL settle_first_pulse: got %b expected %b", o, e); end
    end
    drive_break(3'b101);
    push_expect(3'b100);
    seen    = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_gated);
      if (!bus.halt_req_o) dropped = 1'b1;
      if (bus.set_broken_o != 3'b000) begin seen = 1'b1; break; end
    end
    tests++; if (dropped !== 1'b0) begin fails++; $display("[TB] FAIL settle_halt_held: got dropped=%0b expected 0", dropped); end
    tests++;
    if (!seen || sbq.size() == 0) begin
      fails++; $display("[TB] FAIL settle_second_pulse: got no pulse or no queued entry (seen=%0b)", seen);
    end else begin
      e = sbq.pop_front();
      o = {bus.set_broken_o, bus.replica_en_o, bus.voter_mode_o, bus.reconfig_count_o};
      if (o !== e) begin fails++; $display("[TB] FAIL settle_second_pulse: got %b expected %b", o, e); end
    end
    wait_halt_low(12, n);
    bus.halt_ack_i = 1'b0;
  endtask

  task automatic test_fatal();
    bit         seen;
    bit         bad;
    int         n;
    exp_t       e;
    exp_t       o;
    logic [2:0] seq [3];
    logic [2:0] lvl [3];
    seq = '{3'b010, 3'b001, 3'b100};
    lvl = '{3'b010, 3'b011, 3'b111};
    do_reset();
    bus.halt_ack_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      drive_break(lvl[s]);
      push_expect(seq[s]);
      wait_pulse(12, seen);
      tests++;
      if (!seen || sbq.size() == 0) begin
        fails++; $display("[TB] FAIL fatal_pulse%0d: got no pulse or no queued entry (seen=%0b)", s, seen);
      end else begin
        e = sbq.pop_front();
        o = {bus.set_broken_o, bus.replica_en_o, bus.voter_mode_o, bus.reconfig_count_o};
        if (o !== e) begin fails++; $display("[TB] FAIL fatal_pulse%0d: got %b expected %b", s, o, e); end
      end
      if (s < 2) wait_halt_low(12, n);
    end
    tests++; if ({bus.fatal_o, bus.halt_req_o} !== 2'b11) begin fails++; $display("[TB] FAIL fatal_flags: got %b expected 11", {bus.fatal_o, bus.halt_req_o}); end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_gated);
      #1;
      bus.is_broken_i = 3'($urandom_range(0, 7));
      bus.halt_ack_i  = 1'($urandom_range(0, 1));
      @(negedge clk_gated);
      if (bus.set_broken_o != 3'b000 || bus.replica_en_o != 3'b000 || bus.voter_mode_o != 2'b11 ||
          !bus.fatal_o || !bus.halt_req_o) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("[TB] FAIL fatal_absorbing: got disturbance %b expected 0", bad); end
    bus.halt_ack_i = 1'b0;
  endtask

  task automatic test_reset_in_settle();
    bit   seen;
    bit   bad;
    exp_t e;
    exp_t o;
    do_reset();
    bus.halt_ack_i  = 1'b1;
    bus.is_broken_i = 3'b010;
    push_expect(3'b010);
    wait_pulse(10, seen);
    tests++;
    if (!seen || sbq.size() == 0) begin
      fails++; $display("[TB] FAIL rst_settle_pulse: got no pulse or no queued entry (seen=%0b)", seen);
    end else begin
      e = sbq.pop_front();
      o = {bus.set_broken_o, bus.replica_en_o, bus.voter_mode_o, bus.reconfig_count_o};
      if (o !== e) begin fails++; $display("[TB] FAIL rst_settle_pulse: got %b expected %b", o, e); end
    end
    @(negedge clk_gated);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.halt_req_o, bus.set_broken_o, bus.replica_en_o, bus.voter_mode_o, bus.fatal_o, bus.timeout_o, bus.reconfig_count_o}
        !== {1'b0, 3'b000, 3'b111, 2'b00, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("[TB] FAIL rst_async: got halt=%b sb=%b en=%b vm=%b fatal=%b to=%b cnt=%0d expected 0 000 111 00 0 0 0",
               bus.halt_req_o, bus.set_broken_o, bus.replica_en_o, bus.voter_mode_o, bus.fatal_o, bus.timeout_o, bus.reconfig_count_o);
    end
    bus.is_broken_i = 3'b000;
    bus.halt_ack_i  = 1'b0;
    model_mask      = 3'b000;
    model_cnt       = 8'd0;
    repeat (2) @(posedge clk_gated);
    @(negedge clk_gated);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_gated);
      if (bus.set_broken_o != 3'b000 || bus.halt_req_o || bus.replica_en_o != 3'b111) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("[TB] FAIL rst_no_mask_kept: got disturbance %b expected 0", bad); end
    tests++; if (sbq.size() != 0) begin fails++; $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size()); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_break();
    test_simultaneous();
    test_timeout();
    test_settle_second_break();
    test_fatal();
    test_reset_in_settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
